// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states, byte lanes per word, default imem depth
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_e;
  localparam int LANES = 4;
  localparam int DEF_DEPTH = 8192;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link (i_start, i_byte_valid/data, o_byte_ready) plus imem write port and status (o_wr_*, o_core_rst_n, o_busy, o_done, o_err)
interface imem_loader_if;
  logic        i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_core_rst_n;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  modport slave (input i_start, i_byte_valid, i_byte_data,
                 output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_core_rst_n, o_busy, o_done, o_err);
  modport master (output i_start, i_byte_valid, i_byte_data,
                  input o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_core_rst_n, o_busy, o_done, o_err);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: little-endian 4-byte assembler; clk_i/rst_ni, clr_i restarts lane count, en_i accepts byte_i, word_o is the word including byte_i, full_o pulses on the 4th byte
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);
  logic [1:0]  lane_q, lane_d;
  logic [23:0] sh_q, sh_d;
  always_comb begin
    word_o = {byte_i, sh_q};
    full_o = en_i && lane_q == 2'(LANES - 1);
    sh_d   = en_i ? word_o[31:8] : sh_q;
    lane_d = clr_i ? 2'd0 : en_i ? lane_q + 2'd1 : lane_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      lane_q <= '0;
      sh_q   <= '0;
    end else begin
      lane_q <= lane_d;
      sh_q   <= sh_d;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader taking a count-prefixed byte image over bus (slave) and writing sequential imem words; i_clk, async active-low i_rst_n
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  imem_loader_if.slave bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic [31:0]        addr_q, addr_d, data_q, data_d, word;
  logic               ready_q, busy_q, wr_en_q, done_q, err_q, core_q;
  logic               fire, full, start_ok;
  assign fire     = bus.i_byte_valid && ready_q;
  assign start_ok = bus.i_start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  imem_loader_byte_packer u_pack (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (start_ok),
    .en_i  (fire),
    .byte_i(bus.i_byte_data),
    .word_o(word),
    .full_o(full)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = start_ok ? HDR : state_q;
      HDR: if (full) begin
        cnt_d   = CNT_W'(word);
        idx_d   = '0;
        state_d = word > 32'(DEPTH) ? ERR : word == '0 ? DONE : DATA;
      end
      DATA: if (full) begin
        data_d  = word;
        addr_d  = BASE_ADDR + (32'(idx_q) << 2);
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + CNT_W'(1);
        state_d = idx_d == cnt_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      core_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= state_d == HDR || state_d == DATA;
      busy_q  <= state_d == HDR || state_d == DATA || state_d == WRITE;
      wr_en_q <= state_d == WRITE;
      done_q  <= state_d == DONE;
      err_q   <= state_d == ERR;
      core_q  <= state_d == DONE;
    end
  assign bus.o_byte_ready = ready_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = addr_q;
  assign bus.o_wr_data    = data_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;
  assign bus.o_core_rst_n = core_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the imem write port with sequential word-aligned addresses. Holds the core in reset until the whole image is written. Sits between the host byte link (UART RX or the testbench) and the imem write port; the fetch path reads the same array combinationally.

Parameters:
DEPTH, 8192, imem depth in 32-bit words; the maximum image size.
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.
CNT_W, 32, width of the header word-count field.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  single-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
i_byte_valid  input  1  i_byte_data holds a valid byte.
i_byte_data  input  8  stream byte.
o_byte_ready  output  1  loader can accept a byte this cycle.
o_wr_en  output  1  imem write strobe, one cycle per word.
o_wr_addr  output  32  byte address of the write; bits [1:0] are always 0.
o_wr_data  output  32  assembled instruction word.
o_core_rst_n  output  1  core reset; low until the load completes.
o_busy  output  1  a load is in progress (HDR, DATA or WRITE).
o_done  output  1  image fully written.
o_err  output  1  header count exceeded DEPTH.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0, including o_core_rst_n=0; byte counter, word index and count register cleared.
- Byte transfer occurs on a rising edge with i_byte_valid && o_byte_ready. o_byte_ready is a registered state decode: 1 only in HDR and DATA.
- Frame format: 4-byte word count N (little-endian), then N words of 4 bytes each, little-endian: first byte is bits [7:0].
- States:
  - IDLE: on i_start, go to HDR.
  - HDR: collect 4 bytes into the count register. On the 4th byte: if N > DEPTH, go to ERR; if N == 0, go to DONE; otherwise go to DATA with idx=0.
  - DATA: collect 4 bytes into the shift register. The 4th byte moves to WRITE.
  - WRITE: exactly one cycle with o_wr_en=1, o_wr_addr=BASE_ADDR+{idx,2'b00}, o_wr_data={b3,b2,b1,b0}, o_byte_ready=0. Then idx++. If idx+1 == N, go to DONE; otherwise go to DATA.
  - DONE: o_done=1, o_core_rst_n=1. i_start returns to HDR and drops o_core_rst_n to 0 on the next cycle.
  - ERR: o_err=1, o_core_rst_n=0. i_start goes to HDR and clears o_err.
- Latency: a word write occurs the cycle after its 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- o_wr_addr and o_wr_data are held stable outside WRITE; only o_wr_en qualifies them.
- i_start in HDR, DATA or WRITE is ignored.
- i_byte_valid in IDLE, DONE, ERR or WRITE is not accepted; the source holds the byte.
- Address arithmetic is 32-bit and wraps modulo 2^32. The N ≤ DEPTH check keeps writes inside the array when BASE_ADDR=0.
- An async reset mid-load aborts immediately to IDLE. Partially written words remain in imem; the core stays in reset.
- o_busy = state is HDR, DATA or WRITE.

Decomposition:
- The shared package holds the state enum (IDLE, HDR, DATA, WRITE, DONE, ERR), the byte-lane constant (4 bytes per word) and the default DEPTH.
- One natural sub-module, byte_packer: a 4-byte little-endian shift/assemble register with a 2-bit lane counter and a word_full pulse. It is reused for both the header and the data words.

Test Plan:
- Reset, then start, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> writes addr 0x0 data 0x00100513 and addr 0x4 data 0x00200593; o_done=1; o_core_rst_n=1; exactly 2 o_wr_en pulses.
- Header 00 00 00 00 -> DONE with no o_wr_en pulse; o_byte_ready=0 afterwards.
- Header 01 20 00 00 (N=8193) -> o_err=1, o_core_rst_n=0, no writes. A following i_start plus a valid 1-word frame -> o_err=0, o_done=1.
- Random i_byte_valid gaps and a held byte during WRITE -> identical write sequence; no byte lost or duplicated.
- Async i_rst_n low after 6 data bytes of a 3-word frame -> all outputs 0 in the same cycle; a subsequent full load succeeds with addr starting at 0x0.
- i_start pulsed during DATA -> ignored, and the load completes normally. i_start in DONE -> o_core_rst_n=0 on the next cycle and state HDR.
